colisor_disparo: RTL and testbench
==================================

Name: colisor_disparo

Overview:
- Memory client that resolves one shot against a player's board through the shared memory controller.
- Uses the controller's colisor port: raises readyColisor, reads the target row, classifies the cell, writes back the marked row and reports the result.
- Board layout: 32 rows × 64-bit words per player; 32 columns × 2-bit cells per row.

Parameters:
- READ_WAIT, 3, cycles readyColisor is held (with mem_busy low) before dataReadColisor is sampled; covers controller next-state plus state-register latency.
- WRITE_HOLD, 2, cycles colisor_wrepN stays high during write-back.
- MAX_ACERTOS, 7'd127, saturation value of the per-player hit counters.

Ports:
- clk  in  1  system clock
- resetGeral  in  1  synchronous reset, active-high
- tiro_valid  in  1  shot request; accepted only when tiro_ready=1
- tiro_x  in  5  column 0..31
- tiro_y  in  5  row 0..31, used as the memory address
- tiro_jogador  in  1  target board: 0 = P1, 1 = P2
- tiro_ready  out  1  high in IDLE only
- mem_busy  in  1  validator holds the controller; the wait counter is frozen while high
- dataReadColisor  in  64  row read via the controller
- readyColisor  out  1  memory request to the controller
- jogadorColisor  out  1  board select to the controller
- colisor_addr  out  5  row address
- colisor_data  out  64  write-back row
- colisor_wrep1  out  1  write enable, P1 memory
- colisor_wrep2  out  1  write enable, P2 memory
- resultado_valid  out  1  one-cycle result pulse
- acerto  out  1  shot hit a ship; valid with resultado_valid
- repetido  out  1  cell already shot; valid with resultado_valid
- acertos_p1  out  7  hits recorded on P1 board
- acertos_p2  out  7  hits recorded on P2 board

Behaviour:
- Cell encoding, bits [2x+1:2x]: 00 water, 01 ship, 10 miss, 11 hit.
- Reset (resetGeral=1 at a clk edge) forces IDLE. All outputs are 0 except tiro_ready=1; counters clear.
- Reset mid-operation aborts at once; no write is issued afterwards.
- Shot capture: on tiro_valid & tiro_ready, x, y and jogador are registered. Inputs are ignored in any other state.
- IDLE -> REQ on accept.
- REQ:
  - readyColisor=1; colisor_addr=y; jogadorColisor=jogador.
  - wait_cnt increments only when mem_busy=0.
  - When wait_cnt reaches READ_WAIT, the row is captured from dataReadColisor; go to CHECK.
- CHECK (1 cycle), classify the captured cell:
  - 00 -> new cell 10, acerto=0.
  - 01 -> new cell 11, acerto=1; the hit counter for the target board increments, saturating at MAX_ACERTOS.
  - 10 or 11 -> repetido=1; skip WRITE and go to RELEASE.
  - Otherwise, colisor_data = captured row with only cell x replaced; go to WRITE.
- WRITE:
  - readyColisor=1.
  - colisor_wrep1 = (jogador==0), colisor_wrep2 = (jogador==1); never both.
  - Held WRITE_HOLD cycles, counted only while mem_busy=0. If mem_busy rises, wren drops and resumes when it clears.
  - Then go to RELEASE.
- RELEASE (1 cycle): readyColisor=0, wren=0.
- DONE (1 cycle): resultado_valid=1 with acerto/repetido; then IDLE. acerto/repetido clear in IDLE.
- Latency with mem_busy=0, accept to resultado_valid:
  - new cell: READ_WAIT+WRITE_HOLD+3 cycles;
  - repeated cell: READ_WAIT+3 cycles.
- colisor_data and colisor_addr stay stable throughout REQ..RELEASE. colisor_data is 0 outside WRITE.
- Column indexing is plain 2·x. All 32 columns are legal; x=31 addresses bits [63:62]. No wrap.

Decomposition:
- Shared package:
  - cell constants AGUA/NAVIO/ERRO/ACERTO;
  - board geometry (32 rows, 32 columns, 2-bit cell, 64-bit word);
  - state encoding.
- One sub-module, atualiza_celula: combinational row/column -> {old cell, new row, acerto, repetido}. Reusable by the validator.

Test Plan:
- Default parameters, P1 row 5 = 64'h0000_0000_0000_0004 (ship at x=1), shot x=1 y=5 jogador=0:
  - read after 3 cycles of readyColisor;
  - colisor_wrep1 high 2 cycles with data 64'h...000C;
  - acerto=1; acertos_p1=1; latency 8.
- Shot at a water cell x=31 y=0, P2, row 0:
  - colisor_data=64'h8000_0000_0000_0000, wrep2 only;
  - acerto=0, repetido=0.
- Repeat of the first shot, row now ...000C:
  - repetido=1, no wren asserted, counter unchanged;
  - latency 6.
- mem_busy high 4 cycles during REQ, then 3 cycles during WRITE:
  - capture and total write hold are delayed exactly by those amounts;
  - wren is low while busy.
- resetGeral asserted during WRITE:
  - next cycle wren=0, readyColisor=0, tiro_ready=1, counters 0;
  - a new shot is accepted normally.
- 128 hits on P2: acertos_p2 saturates at 127.

Source files
------------

// File: rtl/colisor_disparo_pkg.sv
// colisor_disparo_pkg: board geometry, cell encoding and FSM states shared by the shot resolver
package colisor_disparo_pkg;
  localparam int N_LINHAS  = 32;
  localparam int N_COLUNAS = 32;
  localparam int CELULA_W  = 2;
  localparam int PALAVRA_W = N_COLUNAS * CELULA_W;
  localparam int CNT_W     = 8;
  typedef enum logic [CELULA_W-1:0] {
    AGUA   = 2'b00,
    NAVIO  = 2'b01,
    ERRO   = 2'b10,
    ACERTO = 2'b11
  } celula_t;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CHECK,
    ST_WRITE,
    ST_RELEASE,
    ST_DONE
  } estado_t;
endpackage

// File: rtl/colisor_disparo_if.sv
// colisor_disparo_if: shot request, memory-controller port and result signals of the shot resolver
interface colisor_disparo_if;
  logic        tiro_valid;
  logic [4:0]  tiro_x;
  logic [4:0]  tiro_y;
  logic        tiro_jogador;
  logic        tiro_ready;
  logic        mem_busy;
  logic [63:0] dataReadColisor;
  logic        readyColisor;
  logic        jogadorColisor;
  logic [4:0]  colisor_addr;
  logic [63:0] colisor_data;
  logic        colisor_wrep1;
  logic        colisor_wrep2;
  logic        resultado_valid;
  logic        acerto;
  logic        repetido;
  logic [6:0]  acertos_p1;
  logic [6:0]  acertos_p2;
  modport slave (
    input  tiro_valid, tiro_x, tiro_y, tiro_jogador, mem_busy, dataReadColisor,
    output tiro_ready, readyColisor, jogadorColisor, colisor_addr, colisor_data,
           colisor_wrep1, colisor_wrep2, resultado_valid, acerto, repetido,
           acertos_p1, acertos_p2
  );
  modport master (
    output tiro_valid, tiro_x, tiro_y, tiro_jogador, mem_busy, dataReadColisor,
    input  tiro_ready, readyColisor, jogadorColisor, colisor_addr, colisor_data,
           colisor_wrep1, colisor_wrep2, resultado_valid, acerto, repetido,
           acertos_p1, acertos_p2
  );
endinterface

// File: rtl/colisor_disparo_atualiza_celula.sv
// atualiza_celula: classifies one cell of a board row and returns the row with that cell marked as shot
module atualiza_celula
  import colisor_disparo_pkg::*;
(
  input  logic [PALAVRA_W-1:0] linha_i,
  input  logic [4:0]           coluna_i,
  output celula_t              celula_o,
  output logic [PALAVRA_W-1:0] linha_o,
  output logic                 acerto_o,
  output logic                 repetido_o
);
  logic [5:0] base;
  assign base       = {coluna_i, 1'b0};
  assign celula_o   = celula_t'(linha_i[base +: CELULA_W]);
  assign acerto_o   = celula_o == NAVIO;
  assign repetido_o = celula_o == ERRO || celula_o == ACERTO;
  always_comb begin
    linha_o = linha_i;
    linha_o[base +: CELULA_W] = acerto_o ? ACERTO : ERRO;
  end
endmodule

// File: rtl/colisor_disparo.sv
// colisor_disparo: resolves one shot via the controller's colisor port (read row, mark cell, write back, report)
module colisor_disparo
  import colisor_disparo_pkg::*;
#(
  parameter int         READ_WAIT   = 3,
  parameter int         WRITE_HOLD  = 2,
  parameter logic [6:0] MAX_ACERTOS = 7'd127
) (
  input logic               clk,
  input logic               resetGeral,
  colisor_disparo_if.slave  bus
);
  estado_t              estado_q, estado_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]           x_q, x_d, y_q, y_d;
  logic                 jog_q, jog_d;
  logic [PALAVRA_W-1:0] linha_q, linha_d;
  logic                 acerto_q, acerto_d, repetido_q, repetido_d;
  logic [6:0]           p1_q, p1_d, p2_q, p2_d;
  celula_t              cel_antiga;
  logic [PALAVRA_W-1:0] linha_nova;
  logic                 hit, rep, wren;

  atualiza_celula u_cel (
    .linha_i    (linha_q),
    .coluna_i   (x_q),
    .celula_o   (cel_antiga),
    .linha_o    (linha_nova),
    .acerto_o   (hit),
    .repetido_o (rep)
  );

  always_ff @(posedge clk) begin
    if (resetGeral) begin
      estado_q    <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      jog_q       <= 1'b0;
      linha_q     <= '0;
      acerto_q    <= 1'b0;
      repetido_q  <= 1'b0;
      p1_q        <= '0;
      p2_q        <= '0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      jog_q       <= jog_d;
      linha_q     <= linha_d;
      acerto_q    <= acerto_d;
      repetido_q  <= repetido_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
    end
  end

  // The wait counter is shared by the read wait and the write hold; both freeze while the validator holds memory
  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    jog_d      = jog_q;
    linha_d    = linha_q;
    acerto_d   = acerto_q;
    repetido_d = repetido_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    unique case (estado_q)
      ST_IDLE: begin
        acerto_d   = 1'b0;
        repetido_d = 1'b0;
        if (bus.tiro_valid) begin
          x_d      = bus.tiro_x;
          y_d      = bus.tiro_y;
          jog_d    = bus.tiro_jogador;
          cnt_d    = '0;
          estado_d = ST_REQ;
        end
      end
      ST_REQ:
        if (!bus.mem_busy) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(READ_WAIT - 1)) begin
            linha_d  = bus.dataReadColisor;
            cnt_d    = '0;
            estado_d = ST_CHECK;
          end
        end
      ST_CHECK: begin
        linha_d    = linha_nova;
        acerto_d   = hit;
        repetido_d = rep;
        p1_d       = (hit && !jog_q && p1_q != MAX_ACERTOS) ? p1_q + 7'd1 : p1_q;
        p2_d       = (hit &&  jog_q && p2_q != MAX_ACERTOS) ? p2_q + 7'd1 : p2_q;
        estado_d   = (cel_antiga inside {ERRO, ACERTO}) ? ST_RELEASE : ST_WRITE;
      end
      ST_WRITE:
        if (!bus.mem_busy) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WRITE_HOLD - 1)) begin
            cnt_d    = '0;
            estado_d = ST_RELEASE;
          end
        end
      ST_RELEASE: estado_d = ST_DONE;
      ST_DONE:    estado_d = ST_IDLE;
      default:    estado_d = ST_IDLE;
    endcase
  end

  assign wren                = estado_q == ST_WRITE && !bus.mem_busy;
  assign bus.tiro_ready      = estado_q == ST_IDLE;
  assign bus.readyColisor    = estado_q == ST_REQ || estado_q == ST_WRITE;
  assign bus.jogadorColisor  = jog_q;
  assign bus.colisor_addr    = y_q;
  assign bus.colisor_data    = estado_q == ST_WRITE ? linha_q : '0;
  assign bus.colisor_wrep1   = wren && !jog_q;
  assign bus.colisor_wrep2   = wren && jog_q;
  assign bus.resultado_valid = estado_q == ST_DONE;
  assign bus.acerto          = estado_q == ST_DONE && acerto_q;
  assign bus.repetido        = estado_q == ST_DONE && repetido_q;
  assign bus.acertos_p1      = p1_q;
  assign bus.acertos_p2      = p2_q;
endmodule

// File: tb/tb_colisor_disparo.sv
// tb_colisor_disparo: random and directed shots against a board-level reference model with a behavioural memory
module tb_colisor_disparo;
  localparam int RW = 3;
  localparam int WH = 2;

  logic clk = 1'b0;
  logic rst_g;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   viol    = 0;
  logic [63:0] mem     [2][32];
  logic [63:0] exp_mem [2][32];
  int   exp_hits [2];

  colisor_disparo_if b ();

  colisor_disparo #(.READ_WAIT(RW), .WRITE_HOLD(WH), .MAX_ACERTOS(7'd127)) dut (
    .clk        (clk),
    .resetGeral (rst_g),
    .bus        (b.slave)
  );

  always #5 clk = ~clk;

  assign b.dataReadColisor = mem[b.jogadorColisor][b.colisor_addr];

  always @(posedge clk) begin
    if (b.colisor_wrep1) mem[0][b.colisor_addr] <= b.colisor_data;
    if (b.colisor_wrep2) mem[1][b.colisor_addr] <= b.colisor_data;
  end

  always @(negedge clk) begin
    #2;
    if (b.colisor_wrep1 && b.colisor_wrep2) viol++;
    if (b.mem_busy && (b.colisor_wrep1 || b.colisor_wrep2)) viol++;
    if (!b.readyColisor && (b.colisor_data != 64'd0 || b.colisor_wrep1 || b.colisor_wrep2)) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_row(input logic j, input logic [4:0] y, input logic [63:0] v);
    mem[j][y]     = v;
    exp_mem[j][y] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_g = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_g = 1'b0;
    exp_hits[0] = 0;
    exp_hits[1] = 0;
  endtask

  task automatic tiro(input logic [4:0] x, input logic [4:0] y, input logic j, input int bq, input int bw);
    logic [1:0] cel;
    logic rep, hit, got_a, got_r, done;
    int lat, exp_lat, w1, w2, exp_w;
    cel = 2'(exp_mem[j][y] >> (2 * x));
    rep = cel >= 2'd2;
    hit = cel == 2'd1;
    if (!rep) exp_mem[j][y] = exp_mem[j][y] + (64'd2 << (2 * x));
    if (hit && exp_hits[j] < 127) exp_hits[j]++;
    exp_lat = rep ? RW + 3 + bq : RW + WH + 3 + bq + bw;
    exp_w   = rep ? 0 : WH;
    @(negedge clk);
    chk("tiro_ready_idle", 64'(b.tiro_ready), 64'd1);
    b.tiro_x = x;
    b.tiro_y = y;
    b.tiro_jogador = j;
    b.tiro_valid = 1'b1;
    lat = 0; w1 = 0; w2 = 0; done = 1'b0; got_a = 1'b0; got_r = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      b.tiro_valid = 1'b0;
      b.mem_busy = (c >= 2 && c < 2 + bq) || (c >= 6 + bq && c < 6 + bq + bw);
      #1;
      w1 += int'(b.colisor_wrep1);
      w2 += int'(b.colisor_wrep2);
      if (b.resultado_valid) begin
        done = 1'b1;
        lat = c;
        got_a = b.acerto;
        got_r = b.repetido;
      end
    end
    b.mem_busy = 1'b0;
    chk("result_seen", 64'(done), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("acerto", 64'(got_a), 64'(hit));
    chk("repetido", 64'(got_r), 64'(rep));
    chk("wrep1_cycles", 64'(w1), 64'(j ? 0 : exp_w));
    chk("wrep2_cycles", 64'(w2), 64'(j ? exp_w : 0));
    chk("acertos_p1", 64'(b.acertos_p1), 64'(exp_hits[0]));
    chk("acertos_p2", 64'(b.acertos_p2), 64'(exp_hits[1]));
    chk("row", mem[j][y], exp_mem[j][y]);
  endtask

  task automatic reset_in_write();
    logic seen;
    set_row(1'b0, 5'd7, 64'd0);
    @(negedge clk);
    b.tiro_x = 5'd3;
    b.tiro_y = 5'd7;
    b.tiro_jogador = 1'b0;
    b.tiro_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      b.tiro_valid = 1'b0;
      #1;
      seen = b.colisor_wrep1;
    end
    chk("write_reached", 64'(seen), 64'd1);
    rst_g = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_wren", 64'({b.colisor_wrep1, b.colisor_wrep2}), 64'd0);
    chk("rst_ready_colisor", 64'(b.readyColisor), 64'd0);
    chk("rst_tiro_ready", 64'(b.tiro_ready), 64'd1);
    chk("rst_counters", 64'({b.acertos_p1, b.acertos_p2}), 64'd0);
    rst_g = 1'b0;
    exp_hits[0] = 0;
    exp_hits[1] = 0;
    exp_mem[0][7] = 64'h80;
    repeat (10) @(negedge clk);
    chk("rst_single_write", mem[0][7], 64'h80);
  endtask

  initial begin
    rst_g = 1'b1;
    b.tiro_valid = 1'b0;
    b.tiro_x = '0;
    b.tiro_y = '0;
    b.tiro_jogador = 1'b0;
    b.mem_busy = 1'b0;
    for (int j = 0; j < 2; j++)
      for (int y = 0; y < 32; y++) set_row(j[0], y[4:0], {$urandom, $urandom});
    exp_hits[0] = 0;
    exp_hits[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_g = 1'b0;
    #1;
    chk("reset_tiro_ready", 64'(b.tiro_ready), 64'd1);
    chk("reset_outputs", 64'({b.readyColisor, b.colisor_wrep1, b.colisor_wrep2,
                              b.resultado_valid, b.acerto, b.repetido, b.jogadorColisor}), 64'd0);
    chk("reset_addr", 64'(b.colisor_addr), 64'd0);
    chk("reset_data", b.colisor_data, 64'd0);
    chk("reset_counters", 64'({b.acertos_p1, b.acertos_p2}), 64'd0);

    set_row(1'b0, 5'd5, 64'h4);
    tiro(5'd1, 5'd5, 1'b0, 0, 0);
    chk("first_row_c", mem[0][5], 64'hC);
    set_row(1'b1, 5'd0, 64'h0);
    tiro(5'd31, 5'd0, 1'b1, 0, 0);
    chk("x31_row", mem[1][0], 64'h8000_0000_0000_0000);
    tiro(5'd1, 5'd5, 1'b0, 0, 0);
    set_row(1'b1, 5'd9, 64'h5555_5555_5555_5555);
    tiro(5'd12, 5'd9, 1'b1, 4, 3);

    for (int i = 0; i < 60; i++)
      tiro(5'($urandom_range(31)), 5'($urandom_range(31)), 1'($urandom_range(1)),
           int'($urandom_range(3)), int'($urandom_range(3)));

    reset_in_write();
    for (int i = 0; i < 10; i++)
      tiro(5'($urandom_range(31)), 5'($urandom_range(31)), 1'($urandom_range(1)), 0, 0);

    do_reset();
    for (int y = 0; y < 32; y++) set_row(1'b1, y[4:0], 64'h5555_5555_5555_5555);
    for (int i = 0; i < 128; i++) tiro(5'(i % 32), 5'(i / 32), 1'b1, 0, 0);
    chk("p2_saturated", 64'(b.acertos_p2), 64'd127);
    chk("bus_violations", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
